// File: rtl/ifu_inst_align.sv
// Fetch realigner: extracts RVC/32-bit instructions from word-aligned icache
// responses, stitches word-straddling instructions and drives PC step/stall.
module ifu_inst_align #(
  parameter int unsigned    XLEN     = 64,
  parameter int unsigned    INST_LEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_i,
  input  logic                resp_valid_i,
  input  logic [XLEN-1:0]     resp_addr_i,
  input  logic [31:0]         resp_data_i,
  output logic                inst_valid_o,
  input  logic                inst_ready_i,
  output logic [INST_LEN-1:0] inst_o,
  output logic [XLEN-1:0]     inst_pc_o,
  output logic                inst_is_rvc_o,
  output logic                stall_o,
  output logic                pc_inc2_o,
  output logic                prefetch_req_o,
  output logic [XLEN-1:0]     prefetch_addr_o
);

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] SPLIT = 1'b1;

  localparam logic [XLEN-1:0] HALF_STEP = XLEN'(2);
  localparam logic [XLEN-3:0] WORD_STEP = (XLEN-2)'(1);

  logic [0:0]          state_q, state_d;
  logic [15:0]         half_buf_q, half_buf_d;
  logic [XLEN-1:0]     half_pc_q, half_pc_d;
  logic                valid_q, valid_d;
  logic [INST_LEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0]     inst_pc_q, inst_pc_d;
  logic                is_rvc_q, is_rvc_d;

  logic        slot_free;
  logic        accept;
  logic        load;
  logic [15:0] half;
  logic        half_rvc;
  logic        split_match;
  logic [XLEN-3:0] word_nxt;

  assign slot_free   = ~valid_q | inst_ready_i;
  assign stall_o     = valid_q & ~inst_ready_i;
  assign accept      = resp_valid_i & ~flush_i & slot_free & ~rst;
  assign half        = resp_addr_i[1] ? resp_data_i[31:16] : resp_data_i[15:0];
  assign half_rvc    = (half[1:0] != 2'b11);
  assign split_match = (resp_addr_i == half_pc_q + HALF_STEP);
  assign word_nxt    = resp_addr_i[XLEN-1:2] + WORD_STEP;

  assign prefetch_addr_o = {word_nxt, 2'b00};

  always_comb begin
    state_d        = state_q;
    half_buf_d     = half_buf_q;
    half_pc_d      = half_pc_q;
    inst_d         = inst_q;
    inst_pc_d      = inst_pc_q;
    is_rvc_d       = is_rvc_q;
    load           = 1'b0;
    prefetch_req_o = 1'b0;
    pc_inc2_o      = 1'b0;

    if (accept) begin
      if (state_q == RUN) begin
        if (half_rvc) begin
          load      = 1'b1;
          inst_d    = {16'h0, half};
          inst_pc_d = resp_addr_i;
          is_rvc_d  = 1'b1;
          pc_inc2_o = 1'b1;
        end else if (!resp_addr_i[1]) begin
          load      = 1'b1;
          inst_d    = resp_data_i;
          inst_pc_d = resp_addr_i;
          is_rvc_d  = 1'b0;
        end else begin
          half_buf_d     = resp_data_i[31:16];
          half_pc_d      = resp_addr_i;
          prefetch_req_o = 1'b1;
          state_d        = SPLIT;
        end
      end else if (split_match) begin
        // PC now sits at half_pc+2; the +2 step lands it on half_pc+4.
        load      = 1'b1;
        inst_d    = {resp_data_i[15:0], half_buf_q};
        inst_pc_d = half_pc_q;
        is_rvc_d  = 1'b0;
        pc_inc2_o = 1'b1;
        state_d   = RUN;
      end
    end

    if (flush_i) begin
      state_d = RUN;
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
    end else if (inst_ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      half_buf_q <= '0;
      half_pc_q  <= '0;
      valid_q    <= 1'b0;
      inst_q     <= '0;
      inst_pc_q  <= RESET_PC;
      is_rvc_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      half_buf_q <= half_buf_d;
      half_pc_q  <= half_pc_d;
      valid_q    <= valid_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
      is_rvc_q   <= is_rvc_d;
    end
  end

  assign inst_valid_o  = valid_q;
  assign inst_o        = inst_q;
  assign inst_pc_o     = inst_pc_q;
  assign inst_is_rvc_o = is_rvc_q;

endmodule
